// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM link (receive-side demux and transmit-side mux).
//   tdm_state_e      : lock state machine encoding (HUNT, LOCK)
//   TDM_N_CH_DEFAULT : default channel (slot) count per frame
//   TDM_W_DEFAULT    : default channel word / beat width
//   slot_w()         : width of a slot index for a given channel count
// -----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    localparam int unsigned TDM_N_CH_DEFAULT = 4;
    localparam int unsigned TDM_W_DEFAULT    = 8;

    // Never returns 0, so a slot index is always at least one bit wide.
    function automatic int unsigned slot_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
// Slot position counter for a TDM frame of N_CH slots.
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset (slot -> 0)
//   load1_i      : sync beat seen; slot 0 has just been taken, so go to 1
//   adv_i        : data beat accepted; step forward, wrapping N_CH-1 -> 0
//   slot_o       : current slot index (0..N_CH-1)
//   last_slot_o  : slot_o is the final slot of the frame
// load1_i has priority over adv_i. With neither asserted the count holds.
// -----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH_DEFAULT,
    localparam int unsigned SW  = slot_w(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load1_i,
    input  logic          adv_i,
    output logic [SW-1:0] slot_o,
    output logic          last_slot_o
);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;
    logic          last_slot;

    assign last_slot = (slot_q == SW'(N_CH - 1));

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        slot_d = slot_q;
        if (load1_i) begin
            slot_d = SW'(1);
        end else if (adv_i) begin
            slot_d = last_slot ? '0 : slot_q + SW'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o      = slot_q;
    assign last_slot_o = last_slot;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive-side TDM demultiplexer. Rebuilds N_CH parallel W-bit channel words
// from a serial beat stream whose slot 0 is flagged by sync_i. Words are
// gathered in a shadow buffer and copied to dout all at once when a frame
// completes. A HUNT/LOCK state machine drops malformed frames and
// resynchronises on the next sync beat.
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset
//   din_valid    : beat present on din this cycle
//   din          : beat data (W bits)
//   sync_i       : marks slot 0 of a frame (qualified by din_valid)
//   dout         : channel words, channel k at bits [k*W +: W]
//   frame_valid  : one-cycle pulse when dout updates
//   locked       : high while in LOCK
//   sync_err     : one-cycle pulse on a framing error
//   err_cnt      : saturating framing-error count (TDM_DEMUX_ERRCNT_EN only)
// Optional feature macro: TDM_DEMUX_ERRCNT_EN adds the err_cnt port/counter.
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH_DEFAULT,
    parameter int unsigned W    = TDM_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din_valid,
    input  logic [W-1:0]    din,
    input  logic            sync_i,
    output logic [N_CH*W-1:0] dout,
    output logic            frame_valid,
    output logic            locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [7:0]      err_cnt,
`endif
    output logic            sync_err
);

    localparam int unsigned SW = slot_w(N_CH);

    tdm_state_e          state_q;
    logic [SW-1:0]       slot;
    logic                last_slot;
    logic [W-1:0]        shadow_q [N_CH];
    logic [N_CH*W-1:0]   dout_q;
    logic                frame_valid_q;
    logic                sync_err_q;
    logic                locked_q;

    // Beat classification
    logic load1;      // any sync beat: slot 0 captured, counter to 1
    logic adv;        // data beat inside a locked frame
    logic commit;     // data beat filling the last slot
    logic early;      // sync beat while a partial frame is open
    logic miss;       // data beat where a sync was expected
    logic sync_err_d;
    logic [N_CH*W-1:0] commit_word;

    always_comb begin
        load1  = din_valid && sync_i;
        adv    = din_valid && !sync_i && (state_q == LOCK) && (slot != '0);
        miss   = din_valid && !sync_i && (state_q == LOCK) && (slot == '0);
        early  = din_valid && sync_i  && (state_q == LOCK) && (slot != '0);
        commit = adv && last_slot;
        sync_err_d = early || miss;
    end

    // The final lane comes straight from din so the frame commits on the edge
    // that samples its last beat, without waiting for the shadow write.
    always_comb begin
        commit_word = '0;
        for (int k = 0; k < int'(N_CH) - 1; k++) begin
            commit_word[k*W +: W] = shadow_q[k];
        end
        commit_word[(N_CH-1)*W +: W] = din;
    end

    tdm_slot_ctr #(
        .N_CH (N_CH)
    ) u_slot_ctr (
        .clk         (clk),
        .rst         (rst),
        .load1_i     (load1),
        .adv_i       (adv),
        .slot_o      (slot),
        .last_slot_o (last_slot)
    );

    // HUNT in slot 0 stays at slot 0, so a missing sync needs no counter
    // action: the counter already sits at 0 when it is detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            dout_q        <= '0;
            // NOTE: the shadow buffer is a small register array, so it is
            // reset along with everything else rather than left undefined.
            for (int k = 0; k < int'(N_CH); k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            frame_valid_q <= commit;
            sync_err_q    <= sync_err_d;

            if (load1) begin
                state_q     <= LOCK;
                locked_q    <= 1'b1;
                shadow_q[0] <= din;
            end else if (miss) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
            end

            if (adv) begin
                shadow_q[slot] <= din;
            end

            if (commit) begin
                dout_q <= commit_word;
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (sync_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
// Self-checking bench for tdm_demux (N_CH=4, W=8). Directed scenarios check
// fixed expected words; a randomized run is compared cycle by cycle against a
// queue-based frame model. Build with TDM_DEMUX_ERRCNT_EN to also cover err_cnt.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_valid = 1'b0;
    logic [W-1:0]      din = '0;
    logic              sync_i = 1'b0;
    logic [N_CH*W-1:0] dout;
    logic              frame_valid;
    logic              locked;
    logic              sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]        err_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .sync_i      (sync_i),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
`ifdef TDM_DEMUX_ERRCNT_EN
        .err_cnt     (err_cnt),
`endif
        .sync_err    (sync_err)
    );

    // ---------------- reference model (frame-level) ----------------
    bit         m_locked;
    logic [7:0] m_part[$];          // words of the frame currently being gathered
    logic [7:0] m_word [N_CH];      // last committed frame
    bit         m_fv;
    bit         m_se;
    int         m_errcnt;

    function automatic logic [N_CH*W-1:0] model_dout();
        logic [N_CH*W-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*W +: W] = m_word[k];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_part.delete();
        for (int k = 0; k < N_CH; k++) m_word[k] = '0;
        m_fv = 0;
        m_se = 0;
        m_errcnt = 0;
    endtask

    // Drive one cycle, advance the model, and leave time at edge+1.
    task automatic step(input bit v, input bit s, input logic [7:0] d);
        din_valid = v;
        sync_i    = s;
        din       = d;
        @(posedge clk);
        m_fv = 0;
        m_se = 0;
        if (v) begin
            if (s) begin
                if (m_locked && m_part.size() != 0) m_se = 1;
                m_part.delete();
                m_part.push_back(d);
                m_locked = 1;
            end else if (m_locked) begin
                if (m_part.size() == 0) begin
                    m_se = 1;
                    m_locked = 0;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == N_CH) begin
                        for (int k = 0; k < N_CH; k++) m_word[k] = m_part[k];
                        m_part.delete();
                        m_fv = 1;
                    end
                end
            end
        end
        if (m_se && m_errcnt < 255) m_errcnt++;
        #1;
        din_valid = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int fv_seen = 0;
        int se_seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00);
            fv_seen += int'(frame_valid);
            se_seen += int'(sync_err);
        end
        tests_run++;
        if (dout !== '0) begin
            tests_failed++;
            $display("FAIL reset_dout: got %h want 0", dout);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_locked: got %b want 0", locked);
        end
        tests_run++;
        if (fv_seen != 0 || se_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_pulses: frame_valid %0d sync_err %0d want 0/0", fv_seen, se_seen);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] beats [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int early_fv = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, i == 0, beats[i]);
            if (i < 3) early_fv += int'(frame_valid);
        end
        tests_run++;
        if (early_fv != 0 || frame_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_fv: early %0d final %b want 0/1", early_fv, frame_valid);
        end
        tests_run++;
        if (dout !== 32'hD4C3B2A1) begin
            tests_failed++;
            $display("FAIL single_dout: got %h want d4c3b2a1", dout);
        end
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_locked: got %b want 1", locked);
        end
        step(0, 0, 8'h00);
        tests_run++;
        if (frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_fv_width: got %b want 0", frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        int fv_cnt = 0;
        int se_cnt = 0;
        // {valid, sync, data}: second frame has gaps inside it
        logic [9:0] seq [11] = '{
            {1'b1, 1'b1, 8'h11}, {1'b1, 1'b0, 8'h12}, {1'b1, 1'b0, 8'h13}, {1'b1, 1'b0, 8'h14},
            {1'b1, 1'b1, 8'h21}, {1'b0, 1'b1, 8'hEE}, {1'b1, 1'b0, 8'h22}, {1'b0, 1'b0, 8'hEE},
            {1'b0, 1'b1, 8'hEE}, {1'b1, 1'b0, 8'h23}, {1'b1, 1'b0, 8'h24}};
        for (int i = 0; i < 11; i++) begin
            logic [9:0] e;
            e = seq[i];
            step(e[9], e[8], e[7:0]);
            fv_cnt += int'(frame_valid);
            se_cnt += int'(sync_err);
        end
        tests_run++;
        if (fv_cnt != 2) begin
            tests_failed++;
            $display("FAIL b2b_fv_count: got %0d want 2", fv_cnt);
        end
        tests_run++;
        if (se_cnt != 0) begin
            tests_failed++;
            $display("FAIL b2b_sync_err: got %0d want 0", se_cnt);
        end
        tests_run++;
        if (dout !== 32'h24232221) begin
            tests_failed++;
            $display("FAIL b2b_dout: got %h want 24232221", dout);
        end
    endtask

    task automatic test_early_sync();
        int fv_cnt = 0;
        int se_cnt = 0;
        step(1, 1, 8'h11);
        step(1, 0, 8'h12);
        step(1, 1, 8'h55);
        tests_run++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || dout !== 32'h24232221) begin
            tests_failed++;
            $display("FAIL early_sync_pulse: sync_err %b fv %b dout %h want 1/0/24232221",
                     sync_err, frame_valid, dout);
        end
        se_cnt += int'(sync_err);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h66 + 8'(i * 17));
            fv_cnt += int'(frame_valid);
            se_cnt += int'(sync_err);
        end
        tests_run++;
        if (fv_cnt != 1 || se_cnt != 1) begin
            tests_failed++;
            $display("FAIL early_counts: fv %0d sync_err %0d want 1/1", fv_cnt, se_cnt);
        end
        tests_run++;
        if (dout !== 32'h88776655) begin
            tests_failed++;
            $display("FAIL early_dout: got %h want 88776655", dout);
        end
    endtask

    task automatic test_missing_sync();
        step(1, 0, 8'h99);
        tests_run++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_err_lock: sync_err %b locked %b want 1/0", sync_err, locked);
        end
        tests_run++;
        if (dout !== 32'h88776655) begin
            tests_failed++;
            $display("FAIL miss_dout_hold: got %h want 88776655", dout);
        end
        // In HUNT further non-sync beats are silently dropped.
        step(1, 0, 8'h5A);
        tests_run++;
        if (sync_err !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL hunt_discard: sync_err %b locked %b want 0/0", sync_err, locked);
        end
        step(1, 1, 8'h01);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_rise: got %b want 1", locked);
        end
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 0, 8'h04);
        tests_run++;
        if (dout !== 32'h04030201 || frame_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_dout: got %h fv %b want 04030201/1", dout, frame_valid);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 8'h31);
        step(1, 0, 8'h32);
        do_reset();
        tests_run++;
        if (dout !== '0 || locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: dout %h locked %b fv %b se %b want 0/0/0/0",
                     dout, locked, frame_valid, sync_err);
        end
        // A partial frame left before reset must not complete afterwards.
        step(1, 0, 8'h33);
        step(1, 0, 8'h34);
        tests_run++;
        if (frame_valid !== 1'b0 || dout !== '0 || sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_discard: fv %b dout %h se %b want 0/0/0",
                     frame_valid, dout, sync_err);
        end
    endtask

    task automatic test_random();
        int gen_pos = 0;
        int bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 3) != 0);
            s = (gen_pos == 0);
            if ($urandom_range(0, 19) == 0) s = !s;
            if (!v && $urandom_range(0, 1) == 1) s = 1'b1;   // sync on idle cycles is ignored
            step(v, s, 8'($urandom));
            if (v) gen_pos = s ? 1 : (gen_pos + 1) % N_CH;
            tests_run++;
            if (dout !== model_dout() || frame_valid !== m_fv || sync_err !== m_se ||
                locked !== m_locked) begin
                tests_failed++;
                if (bad < 10)
                    $display("FAIL random_c%0d: dout %h fv %b se %b lk %b want %h %b %b %b",
                             c, dout, frame_valid, sync_err, locked,
                             model_dout(), m_fv, m_se, m_locked);
                bad++;
            end
            tests_run++;
            if (frame_valid === 1'b1 && sync_err === 1'b1) begin
                tests_failed++;
                $display("FAIL random_exclusive_c%0d: frame_valid and sync_err both high", c);
            end
`ifdef TDM_DEMUX_ERRCNT_EN
            tests_run++;
            if (err_cnt !== 8'(m_errcnt)) begin
                tests_failed++;
                $display("FAIL random_errcnt_c%0d: got %0d want %0d", c, err_cnt, m_errcnt);
            end
`endif
        end
    endtask

`ifdef TDM_DEMUX_ERRCNT_EN
    task automatic test_errcnt();
        do_reset();
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL errcnt_reset: got %0d want 0", err_cnt);
        end
        // First sync locks; each later sync lands on slot 1 and is an early sync.
        for (int i = 0; i < 301; i++) step(1, 1, 8'(i));
        tests_run++;
        if (err_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL errcnt_saturate: got %0d want 255", err_cnt);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_mid_reset();
        test_random();
`ifdef TDM_DEMUX_ERRCNT_EN
        test_errcnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
